// File: rtl/mac_pipe_sat_if.sv
// Operand/result bundle for the mac_pipe_sat arithmetic core.
// The master drives operands and controls; the slave returns the result and its flags.
interface mac_pipe_sat_if #(
    parameter int W = 12
);
    logic         e;
    logic         in_vld;
    logic         acc_mode;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] y;
    logic         y_vld;
    logic         ovf;

    modport master (
        output e, in_vld, acc_mode, clr, a, b, c,
        input  y, y_vld, ovf
    );

    modport slave (
        input  e, in_vld, acc_mode, clr, a, b, c,
        output y, y_vld, ovf
    );
endinterface

// File: rtl/mac_pipe_sat.sv
// Three-stage pipelined y = sat(a*b + c) / sat(a*b + acc) with per-sample valids,
// overflow flag, synchronous flush (clr) and a global stall enable (e).
module mac_pipe_sat #(
    parameter int W   = 12,
    parameter bit SAT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    mac_pipe_sat_if.slave      bus
);
    localparam int           PW    = 2 * W;
    localparam logic [W-1:0] Y_MAX = {W{1'b1}};

    // Clamp to the W-bit maximum when saturating; otherwise keep the low W bits.
    function automatic logic [W-1:0] fit_result(input logic [PW:0] sum);
        if (SAT && (|sum[PW:W])) begin
            return Y_MAX;
        end else begin
            return sum[W-1:0];
        end
    endfunction

    logic [W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
    logic          s1_am_q, s1_am_d, s1_vld_q, s1_vld_d;
    logic [PW-1:0] s2_prod_q, s2_prod_d;
    logic [W-1:0]  s2_c_q, s2_c_d;
    logic          s2_am_q, s2_am_d, s2_vld_q, s2_vld_d;
    logic [W-1:0]  acc_q, acc_d, y_q, y_d;
    logic          ovf_q, ovf_d, y_vld_q, y_vld_d;

    logic [W-1:0]  addend_s;
    logic [PW:0]   sum_s;
    logic [PW-1:0] prod_s;

    assign prod_s   = {{W{1'b0}}, s1_a_q} * {{W{1'b0}}, s1_b_q};
    assign addend_s = s2_am_q ? acc_q : s2_c_q;
    assign sum_s    = {1'b0, s2_prod_q} + {{(W + 1){1'b0}}, addend_s};

    // Next-state logic: clr flushes, e advances all stages, otherwise everything holds.
    always_comb begin
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_c_d    = s1_c_q;
        s1_am_d   = s1_am_q;
        s1_vld_d  = s1_vld_q;
        s2_prod_d = s2_prod_q;
        s2_c_d    = s2_c_q;
        s2_am_d   = s2_am_q;
        s2_vld_d  = s2_vld_q;
        acc_d     = acc_q;
        y_d       = y_q;
        ovf_d     = ovf_q;
        y_vld_d   = 1'b0;

        if (bus.clr) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
            acc_d    = {W{1'b0}};
            y_d      = {W{1'b0}};
            ovf_d    = 1'b0;
        end else if (bus.e) begin
            s1_a_d    = bus.a;
            s1_b_d    = bus.b;
            s1_c_d    = bus.c;
            s1_am_d   = bus.acc_mode;
            s1_vld_d  = bus.in_vld;
            s2_prod_d = prod_s;
            s2_c_d    = s1_c_q;
            s2_am_d   = s1_am_q;
            s2_vld_d  = s1_vld_q;
            // acc tracks y, so chained accumulate samples see the result of the previous one.
            if (s2_vld_q) begin
                y_d     = fit_result(sum_s);
                acc_d   = fit_result(sum_s);
                ovf_d   = |sum_s[PW:W];
                y_vld_d = 1'b1;
            end else begin
                y_vld_d = 1'b0;
            end
        end else begin
            y_vld_d = 1'b0;
        end
    end

    // Pipeline, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_q    <= {W{1'b0}};
            s1_b_q    <= {W{1'b0}};
            s1_c_q    <= {W{1'b0}};
            s1_am_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s2_prod_q <= {PW{1'b0}};
            s2_c_q    <= {W{1'b0}};
            s2_am_q   <= 1'b0;
            s2_vld_q  <= 1'b0;
            acc_q     <= {W{1'b0}};
            y_q       <= {W{1'b0}};
            ovf_q     <= 1'b0;
            y_vld_q   <= 1'b0;
        end else begin
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_c_q    <= s1_c_d;
            s1_am_q   <= s1_am_d;
            s1_vld_q  <= s1_vld_d;
            s2_prod_q <= s2_prod_d;
            s2_c_q    <= s2_c_d;
            s2_am_q   <= s2_am_d;
            s2_vld_q  <= s2_vld_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            ovf_q     <= ovf_d;
            y_vld_q   <= y_vld_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.y_vld = y_vld_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_mac_pipe_sat.sv
// Random + directed bench for mac_pipe_sat: a saturating and a wrapping instance share
// stimulus and are compared against a queue-based arithmetic reference.
module tb_mac_pipe_sat;
    localparam int     W    = 12;
    localparam longint MAXV = (longint'(1) << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mac_pipe_sat_if #(.W(W)) if_s ();
    mac_pipe_sat_if #(.W(W)) if_w ();

    mac_pipe_sat #(.W(W), .SAT(1'b1)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    mac_pipe_sat #(.W(W), .SAT(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applied inputs, mirrored so the reference sees exactly what the DUT samples.
    logic   d_e, d_vld, d_am, d_clr;
    longint d_a, d_b, d_c;

    typedef struct {
        longint a;
        longint b;
        longint c;
        bit     am;
        int     rem;
    } ent_t;

    ent_t   pend[$];
    longint m_y[2];
    longint m_acc[2];
    bit     m_ovf[2];
    bit     m_vld;

    task automatic drive(input logic e, input logic vld, input logic am, input logic clr,
                         input longint a, input longint b, input longint c);
        d_e = e; d_vld = vld; d_am = am; d_clr = clr; d_a = a; d_b = b; d_c = c;
        if_s.e = e; if_s.in_vld = vld; if_s.acc_mode = am; if_s.clr = clr;
        if_s.a = W'(a); if_s.b = W'(b); if_s.c = W'(c);
        if_w.e = e; if_w.in_vld = vld; if_w.acc_mode = am; if_w.clr = clr;
        if_w.a = W'(a); if_w.b = W'(b); if_w.c = W'(c);
    endtask

    task automatic model_reset();
        pend.delete();
        m_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_y[k] = 0; m_acc[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    // Reference: each captured sample retires on its third enabled edge, in order.
    task automatic model_edge();
        ent_t   s;
        longint sum;
        if (d_clr) begin
            model_reset();
        end else if (!d_e) begin
            m_vld = 1'b0;
        end else begin
            m_vld = 1'b0;
            foreach (pend[i]) pend[i].rem--;
            if (pend.size() > 0 && pend[0].rem == 0) begin
                s = pend.pop_front();
                for (int k = 0; k < 2; k++) begin
                    sum      = s.a * s.b + (s.am ? m_acc[k] : s.c);
                    m_ovf[k] = (sum > MAXV);
                    m_y[k]   = (k == 0 && sum > MAXV) ? MAXV : (sum % (MAXV + 1));
                    m_acc[k] = m_y[k];
                end
                m_vld = 1'b1;
            end
            if (d_vld) begin
                s.a = d_a; s.b = d_b; s.c = d_c; s.am = d_am; s.rem = 2;
                pend.push_back(s);
            end
        end
    endtask

    task automatic check_out(input string tag);
        check_val({tag, " y_sat"},   64'(if_s.y),     64'(m_y[0]));
        check_val({tag, " ovf_sat"}, 64'(if_s.ovf),   64'(m_ovf[0]));
        check_val({tag, " vld_sat"}, 64'(if_s.y_vld), 64'(m_vld));
        check_val({tag, " y_wrap"},  64'(if_w.y),     64'(m_y[1]));
        check_val({tag, " ovf_wrap"},64'(if_w.ovf),   64'(m_ovf[1]));
        check_val({tag, " vld_wrap"},64'(if_w.y_vld), 64'(m_vld));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_out(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_out(tag);
        #1 rst_n = 1'b1;
    endtask

    int     pulses;
    longint seq[$];

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        model_reset();
        #12;
        check_out("reset");
        rst_n = 1'b1;

        // Basic product plus addend.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 5, 7);
        step("t1 cap");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step("t1 e2");
        step("t1 e3");
        check_val("t1 y", 64'(if_s.y), 64'h016);
        check_val("t1 vld", 64'(if_s.y_vld), 64'd1);
        step("t1 hold");
        check_val("t1 y hold", 64'(if_s.y), 64'h016);

        // Overflow: saturating and wrapping results.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 'hDFC, 'h5B4, 'h0E7);
        step("t2 cap");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step("t2 e2");
        step("t2 e3");
        check_val("t2 y sat",  64'(if_s.y),   64'hFFF);
        check_val("t2 ovf sat",64'(if_s.ovf), 64'd1);
        check_val("t2 y wrap", 64'(if_w.y),   64'((3580 * 1460 + 231) % 4096));
        check_val("t2 ovf wrap",64'(if_w.ovf),64'd1);

        // Accumulate chain seeded by clr, then a c-mode sample reseeds acc.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        step("t3 clr");
        seq.delete();
        for (int i = 0; i < 8; i++) begin
            if (i < 4)       drive(1'b1, 1'b1, 1'b1, 1'b0, 2, 3, 0);
            else if (i == 4) drive(1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0);
            else             drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            step("t3 acc");
            if (if_s.y_vld) seq.push_back(longint'(if_s.y));
        end
        check_val("t3 count", 64'(seq.size()), 64'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++)
            check_val("t3 seq", 64'(seq[i]), (i < 4) ? 64'(6 * (i + 1)) : 64'd1);

        // Stall: e low for two cycles after the first pipeline edge.
        pulses = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 5, 7);
        step("t4 cap");
        for (int i = 0; i < 6; i++) begin
            drive((i == 0 || i == 1) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            step("t4 stall");
            if (if_s.y_vld) pulses++;
        end
        check_val("t4 pulses", 64'(pulses), 64'd1);
        check_val("t4 y", 64'(if_s.y), 64'h016);

        // Bubbles, then a flush with two samples in flight.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, i + 1, 2, 1);
            step("t5 bubble");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step("t5 drain");
        step("t5 drain");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 'hFFF, 'hFFF, 5);
        step("t5 s1");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 9, 9, 9);
        step("t5 s2");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        step("t5 clr");
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            step("t5 post");
            if (if_s.y_vld) pulses++;
        end
        check_val("t5 pulses", 64'(pulses), 64'd0);
        check_val("t5 y", 64'(if_s.y), 64'd0);
        check_val("t5 ovf", 64'(if_s.ovf), 64'd0);

        // Asynchronous reset with all stages occupied.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 'hFFF, 'h0FF, 'h123);
            step("t6 fill");
        end
        async_reset("t6 rst");
        check_val("t6 y", 64'(if_s.y), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            step("t6 idle");
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4, 4, 4);
        step("t6 cap");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step("t6 e2");
        step("t6 e3");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            longint ra, rb, rc;
            ra = ($urandom_range(0, 4) == 0) ? MAXV : longint'($urandom_range(0, 4095));
            rb = ($urandom_range(0, 4) == 0) ? MAXV : longint'($urandom_range(0, 4095));
            rc = ($urandom_range(0, 4) == 0) ? MAXV : longint'($urandom_range(0, 4095));
            drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                  ra, rb, rc);
            step("rand");
            if (i % 150 == 149) async_reset("rand rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
